// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the PS/2 scan-code set 2 key-state decoder:
// FSM states, protocol byte values, key indices and the per-player keymap.
package ps2_key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam logic [7:0] KBD_OVF   = 8'h00;
    localparam logic [7:0] KBD_ERR   = 8'hFF;
    localparam logic [7:0] ACK       = 8'hFA;
    localparam logic [7:0] BAT       = 8'hAA;
    localparam logic [7:0] ECHO      = 8'hEE;

    // Pause/Break is E1 followed by seven more bytes
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    localparam int unsigned KEY_UP    = 0;
    localparam int unsigned KEY_DOWN  = 1;
    localparam int unsigned KEY_LEFT  = 2;
    localparam int unsigned KEY_RIGHT = 3;
    localparam int unsigned KEY_HIT   = 4;
    localparam int unsigned KEY_KICK  = 5;

    localparam int unsigned MAX_PLAYERS = 2;
    localparam int unsigned MAX_KEYS    = 6;

    // Entry format {ext, code}; indexed [player][key]
    localparam logic [8:0] KEYMAP [MAX_PLAYERS][MAX_KEYS] = '{
        '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h069, 9'h072},
        '{9'h01D, 9'h01B, 9'h01C, 9'h023, 9'h03B, 9'h042}
    };

endpackage

// File: rtl/ps2_scan_match.sv
// Combinational keymap lookup: {ext, code} -> {hit, player, key}, restricted
// to the configured number of players and keys per player.
module ps2_scan_match
    import ps2_key_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned KEYS_PER_PLAYER = 6
) (
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic       player,
    output logic [2:0] key
);

    always_comb begin
        hit    = 1'b0;
        player = 1'b0;
        key    = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            for (int unsigned k = 0; k < KEYS_PER_PLAYER; k++) begin
                if (!hit && KEYMAP[p][k] == {ext, code}) begin
                    hit    = 1'b1;
                    player = 1'(p);
                    key    = 3'(k);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_key_state.sv
// PS/2 set 2 byte-stream decoder holding an active-low held state per mapped key.
// Optional KEY_EDGE_EN adds key_press, a one-cycle pulse on each released->held transition.
module ps2_key_state
    import ps2_key_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS     = 2,
    parameter int unsigned KEYS_PER_PLAYER = 6,
    parameter int unsigned TIMEOUT_CYC     = 2_500_000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [7:0]                             rx_data,
    input  logic                                   rx_valid,
    output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] key_n,
    output logic                                   seq_err,
    output logic                                   kbd_clr
`ifdef KEY_EDGE_EN
    ,
    output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] key_press
`endif
);

    localparam int unsigned NK = NUM_PLAYERS * KEYS_PER_PLAYER;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    state_t          state, state_nxt;
    logic [TW-1:0]   tmo, tmo_nxt;
    logic [2:0]      skip, skip_nxt;
    logic [NK-1:0]   key_nxt;
    logic            seq_err_nxt;
    logic            clr_all;
    logic            do_make, do_break;

    logic            m_ext, m_hit, m_player;
    logic [2:0]      m_key;
    logic [NK-1:0]   m_mask;

    assign m_ext = (state == EXT) || (state == EXT_BRK);

    ps2_scan_match #(
        .NUM_PLAYERS    (NUM_PLAYERS),
        .KEYS_PER_PLAYER(KEYS_PER_PLAYER)
    ) u_match (
        .ext   (m_ext),
        .code  (rx_data),
        .hit   (m_hit),
        .player(m_player),
        .key   (m_key)
    );

    always_comb begin
        m_mask = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (m_hit && i == 32'(m_player) * KEYS_PER_PLAYER + 32'(m_key)) begin
                m_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_nxt     = tmo;
        skip_nxt    = skip;
        seq_err_nxt = 1'b0;
        clr_all     = 1'b0;
        do_make     = 1'b0;
        do_break    = 1'b0;
        if (rx_valid) begin
            tmo_nxt = '0;
            unique case (state)
                IDLE: begin
                    case (rx_data)
                        PFX_EXT:          state_nxt = EXT;
                        PFX_BRK:          state_nxt = BRK;
                        PFX_PAUSE: begin
                            state_nxt = SKIP;
                            skip_nxt  = PAUSE_TAIL;
                        end
                        KBD_OVF, KBD_ERR: clr_all   = 1'b1;
                        ACK, BAT, ECHO:   ;
                        default:          do_make   = 1'b1;
                    endcase
                end
                EXT: begin
                    if (rx_data == PFX_BRK) begin
                        state_nxt = EXT_BRK;
                    end else if (rx_data != PFX_EXT) begin
                        do_make   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    // F0 E0 is out of order; recover by treating E0 as a fresh prefix
                    if (rx_data == PFX_EXT) begin
                        seq_err_nxt = 1'b1;
                        state_nxt   = EXT;
                    end else begin
                        do_break  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                EXT_BRK: begin
                    do_break  = 1'b1;
                    state_nxt = IDLE;
                end
                SKIP: begin
                    skip_nxt = skip - 3'd1;
                    if (skip == 3'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                state_nxt   = IDLE;
                seq_err_nxt = 1'b1;
                tmo_nxt     = '0;
            end else begin
                tmo_nxt = tmo + TW'(1);
            end
        end

        if (clr_all)       key_nxt = '1;
        else if (do_make)  key_nxt = key_n & ~m_mask;
        else if (do_break) key_nxt = key_n | m_mask;
        else               key_nxt = key_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tmo     <= '0;
            skip    <= '0;
            key_n   <= '1;
            seq_err <= 1'b0;
            kbd_clr <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo     <= tmo_nxt;
            skip    <= skip_nxt;
            key_n   <= key_nxt;
            seq_err <= seq_err_nxt;
            kbd_clr <= clr_all;
        end
    end

`ifdef KEY_EDGE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_press <= '0;
        else     key_press <= do_make ? (key_n & m_mask) : '0;
    end
`endif

endmodule
